// File: rtl/step_clock_ctrl.sv
// rtl/step_clock_ctrl.sv - board execution controller producing the pipeline clock enable
//
// Purpose: turns the raw step button and run switch into one clean clock
// enable (pipe_en) for every pipeline register. Supports free-run, an N-cycle
// burst per button press, and halting on a core request.
//
// Ports:
//   clk          board system clock, rising-edge active
//   reset        asynchronous, active-low reset
//   key_step_n   raw step push button, active-low, bouncing, asynchronous
//   run_sw       raw slide switch, asynchronous; 1 = free-run
//   burst_len    enabled cycles per press (0 behaves as 1)
//   halt         synchronous halt request level from the core
//   pipe_en      clock enable for all pipeline registers
//   step_busy    high while a burst is in progress
//   cycle_count  number of cycles with pipe_en=1 (wraps)
//   state_o      current state code for LEDs
module step_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int BURST_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_step_n,
  input  logic               run_sw,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               halt,
  output logic               pipe_en,
  output logic               step_busy,
  output logic [31:0]        cycle_count,
  output logic [1:0]         state_o
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] BURST  = 2'b10;
  localparam logic [1:0] HALTED = 2'b11;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               key_s1, key_s2;
  logic               run_s1, run_s2;
  logic               halt_q;
  logic [CNT_W-1:0]   db_cnt;
  logic               key_db;
  logic [1:0]         state;
  logic [BURST_W-1:0] remaining;

  logic db_accept;
  logic press;
  logic halt_evt;

  // Two-flop synchronisers; the key idles high (released), the switch low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      key_s1 <= key_step_n;
      key_s2 <= key_s1;
      run_s1 <= run_sw;
      run_s2 <= run_s1;
      halt_q <= halt;
    end
  end

  // The debounced level only changes after the synchronised key has held a
  // different level for DEBOUNCE_CYCLES consecutive cycles. press fires in the
  // same cycle the new low level is accepted, so it is exactly one cycle wide.
  assign db_accept = (key_s2 != key_db) && (db_cnt == DB_LAST);
  assign press     = db_accept && !key_s2;
  assign halt_evt  = halt && !halt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt <= '0;
      key_db <= 1'b1;
    end else if (key_s2 != key_db) begin
      if (db_accept) begin
        key_db <= key_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (halt_evt) begin
            state <= HALTED;
          end else if (run_s2) begin
            state <= RUN;                 // a simultaneous press is dropped
          end else if (press) begin
            state     <= BURST;
            remaining <= (burst_len == '0) ? BURST_W'(1) : burst_len;
          end
        end
        RUN: begin
          if (halt_evt)     state <= HALTED;
          else if (!run_s2) state <= IDLE;
        end
        BURST: begin
          if (halt_evt) begin
            state     <= HALTED;
            remaining <= '0;
          end else if (remaining == BURST_W'(1)) begin
            state     <= IDLE;
            remaining <= '0;
          end else begin
            remaining <= remaining - 1'b1;
          end
        end
        default: begin                    // HALTED: only a press leaves
          if (press) state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cycle_count <= '0;
    else if (pipe_en) cycle_count <= cycle_count + 32'd1;
  end

  assign pipe_en   = (state == RUN) || (state == BURST);
  assign step_busy = (state == BURST);
  assign state_o   = state;

endmodule
